// File: rtl/phys_free_list.sv
// phys_free_list
//   Circular free list of physical register tags for the rename stage.
//   Up to ISSUE_WIDTH tags leave per cycle at the speculative head.
//   Up to COMMIT_WIDTH old tags come back per cycle at the tail.
//   A flush rolls head back to the committed allocation pointer in a
//   single cycle.
//
//   Each pointer carries a wrap bit above the DEPTH index, so DEPTH must
//   be a power of two.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   alloc_req       per-slot request for a new tag
//   alloc_ready     at least ISSUE_WIDTH tags are free (independent of alloc_req)
//   alloc_tag       tag for slot i at [i*PTAG_W +: PTAG_W], 0 for idle slots
//   commit_alloc    per retiring instruction: it had allocated a tag
//   release_valid   per retiring instruction: its old tag is returned
//   release_tag     old tags being returned, packed like alloc_tag
//   flush           mispredict recovery
//   free_count      speculative free entries (tail - head)
//   err_overflow    sticky: release overflow or commit overrun
module phys_free_list #(
    parameter  int NUM_PHYS_REGS = 64,
    parameter  int NUM_ARCH_REGS = 32,
    parameter  int ISSUE_WIDTH   = 4,
    parameter  int COMMIT_WIDTH  = 4,
    localparam int PTAG_W        = $clog2(NUM_PHYS_REGS),
    localparam int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int PTR_W         = $clog2(DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ISSUE_WIDTH-1:0]           alloc_req,
    output logic                             alloc_ready,
    output logic [ISSUE_WIDTH*PTAG_W-1:0]    alloc_tag,
    input  logic [COMMIT_WIDTH-1:0]          commit_alloc,
    input  logic [COMMIT_WIDTH-1:0]          release_valid,
    input  logic [COMMIT_WIDTH*PTAG_W-1:0]   release_tag,
    input  logic                             flush,
    output logic [PTR_W-1:0]                 free_count,
    output logic                             err_overflow
);

    localparam int               IDX_W   = PTR_W - 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ISSUE_P = PTR_W'(ISSUE_WIDTH);

    logic [PTAG_W-1:0] entry [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  commit_head;
    logic [PTR_W-1:0]  tail;

    logic [PTR_W-1:0]  alloc_cnt;
    logic [PTR_W-1:0]  commit_cnt;
    logic [PTR_W-1:0]  rel_cnt;
    logic [IDX_W-1:0]  rel_idx [COMMIT_WIDTH];
    logic              alloc_fire;

    logic [PTR_W-1:0]  head_next;
    logic [PTR_W-1:0]  commit_head_next;
    logic [PTR_W-1:0]  tail_next;
    logic [PTR_W:0]    fc_base;
    logic [PTR_W:0]    fc_sub;
    logic              release_overflow;
    logic              commit_overrun;

    assign free_count  = tail - head;
    assign alloc_ready = (free_count >= ISSUE_P);
    assign alloc_fire  = alloc_ready & (|alloc_req) & ~flush;

    // k-th requesting slot reads entry[head + k]. The index sum is IDX_W
    // bits wide, so it wraps mod DEPTH.
    always_comb begin
        alloc_cnt = '0;
        alloc_tag = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (alloc_req[i]) begin
                alloc_tag[i*PTAG_W +: PTAG_W] = entry[head[IDX_W-1:0] + alloc_cnt[IDX_W-1:0]];
                alloc_cnt = alloc_cnt + PTR_ONE;
            end
        end
    end

    // Compact valid release slots onto consecutive entries starting at tail.
    always_comb begin
        rel_cnt = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            rel_idx[i] = tail[IDX_W-1:0] + rel_cnt[IDX_W-1:0];
            if (release_valid[i]) begin
                rel_cnt = rel_cnt + PTR_ONE;
            end
        end
    end

    always_comb begin
        commit_cnt = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_alloc[i]) begin
                commit_cnt = commit_cnt + PTR_ONE;
            end
        end
    end

    assign commit_head_next = commit_head + commit_cnt;
    assign tail_next        = tail + rel_cnt;

    always_comb begin
        head_next = head;
        if (flush) begin
            head_next = commit_head_next;
        end else if (alloc_fire) begin
            head_next = head + alloc_cnt;
        end
    end

    // Overflow test runs one bit wider than the pointers so that a count
    // above DEPTH is visible instead of wrapping. On a flush the next
    // free count is measured from the committed pointer.
    always_comb begin
        if (flush) begin
            fc_base = {1'b0, tail - commit_head};
            fc_sub  = {1'b0, commit_cnt};
        end else begin
            fc_base = {1'b0, free_count};
            fc_sub  = alloc_fire ? {1'b0, alloc_cnt} : '0;
        end
        release_overflow = (fc_base + {1'b0, rel_cnt}) > ({1'b0, DEPTH_P} + fc_sub);
        commit_overrun   = commit_cnt > (head - commit_head);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            commit_head  <= '0;
            tail         <= DEPTH_P;
            err_overflow <= 1'b0;
        end else begin
            head         <= head_next;
            commit_head  <= commit_head_next;
            tail         <= tail_next;
            err_overflow <= err_overflow | release_overflow | commit_overrun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= PTAG_W'(NUM_ARCH_REGS + i);
            end
        end else begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (release_valid[i]) begin
                    entry[rel_idx[i]] <= release_tag[i*PTAG_W +: PTAG_W];
                end
            end
        end
    end

endmodule
